fir_decim_stream: RTL and testbench

- Parametrised, runtime-programmable decimating FIR for the FM demod chain; successor of the fixed 32-tap, decimate-by-8 FIR stage.
- Accepts samples through a FIFO-style write port and sends decimated results to an internal first-word-fall-through (FWFT) output FIFO.
- Coefficients are loaded at run time, so one block serves the L+R, L-R, pilot and audio filters.
- Uses a single multiplier in a sequential MAC (one tap per cycle).

---
 rtl/fir_decim_stream.sv | 257 +++++++++++++++++++++++++
 tb/tb_fir_decim_stream.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_decim_stream.sv
// -----------------------------------------------------------------------------
// fir_decim_stream
//   Runtime-programmable decimating FIR for the FM demod chain. Samples enter
//   through a FIFO-style write port. Every DECIM-th accepted sample starts a
//   sequential MAC: one shared multiplier, one tap per cycle. The result is
//   pushed into a first-word-fall-through output FIFO.
//
//   Optional build macro:
//     FIR_DECIM_SAT_EN - saturate the final sum to the DATA_WIDTH signed range.
//                        When undefined, the sum wraps (two's complement).
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   din          input sample (signed)
//   in_wr_en     sample write strobe; accepted when in_wr_en && !in_full
//   in_full      high while the filter cannot take a sample (MAC / WRITE)
//   coeff_wr_en  coefficient write strobe (dropped when coeff_ready is low)
//   coeff_addr   tap index k
//   coeff_din    coefficient value c[k] (signed)
//   coeff_ready  high while coefficient writes are accepted (IDLE)
//   dout         head of the output FIFO, valid while !out_empty
//   out_rd_en    pop; ignored while out_empty
//   out_empty    output FIFO empty
//
// OUT_DEPTH must be a power of two and at least 2.
// -----------------------------------------------------------------------------
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | accept samples and coefficient writes, count toward DECIM
//   ST_MAC   | accumulate one tap per cycle, k = 0 .. NUM_TAPS-1
//   ST_WRITE | push result into output FIFO, stall while the FIFO is full
// -----------------------------------------------------------------------------
module fir_decim_stream #(
  parameter int DATA_WIDTH  = 32,
  parameter int COEFF_WIDTH = 32,
  parameter int NUM_TAPS    = 32,
  parameter int DECIM       = 8,
  parameter int FRAC_BITS   = 10,
  parameter int OUT_DEPTH   = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [DATA_WIDTH-1:0]       din,
  input  logic                        in_wr_en,
  output logic                        in_full,
  input  logic                        coeff_wr_en,
  input  logic [$clog2(NUM_TAPS)-1:0] coeff_addr,
  input  logic [COEFF_WIDTH-1:0]      coeff_din,
  output logic                        coeff_ready,
  output logic [DATA_WIDTH-1:0]       dout,
  input  logic                        out_rd_en,
  output logic                        out_empty
);

  localparam int PW  = DATA_WIDTH + COEFF_WIDTH;
  localparam int KW  = $clog2(NUM_TAPS);
  localparam int DCW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW  = $clog2(OUT_DEPTH);
  localparam int OCW = AW + 1;

  localparam logic [KW-1:0]  TAP_LAST  = KW'(NUM_TAPS - 1);
  localparam logic [DCW-1:0] DCNT_LAST = DCW'(DECIM - 1);
  localparam logic [OCW-1:0] FIFO_CAP  = OCW'(OUT_DEPTH);

  // Adding 2^FRAC_BITS-1 before the arithmetic shift turns floor division into
  // truncation toward zero for negative products.
  localparam logic signed [PW-1:0] DQ_BIAS = (PW'(1) << FRAC_BITS) - PW'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_WRITE
  } state_t;

  state_t                         state_q;
  logic signed [DATA_WIDTH-1:0]   x_q [NUM_TAPS];
  logic signed [COEFF_WIDTH-1:0]  c_q [NUM_TAPS];
  logic [DCW-1:0]                 dcnt_q;
  logic [KW-1:0]                  tap_q;
  logic signed [PW-1:0]           acc_q;
  logic                           in_full_q;
  logic                           coeff_ready_q;

  logic                           accept;
  logic                           coeff_we;
  logic signed [DATA_WIDTH-1:0]   x_sel;
  logic signed [COEFF_WIDTH-1:0]  c_sel;
  logic signed [PW-1:0]           x_ext;
  logic signed [PW-1:0]           c_ext;
  logic signed [PW-1:0]           prod;
  logic signed [PW-1:0]           dq;
  logic [DATA_WIDTH-1:0]          y;

  logic                           fifo_full;
  logic                           push;
  logic                           pop;
  logic                           load_head;

  assign accept   = in_wr_en && !in_full_q;
  assign coeff_we = coeff_wr_en && coeff_ready_q;

  // Single shared multiplier, operands selected by the running tap index.
  assign x_sel = x_q[tap_q];
  assign c_sel = c_q[tap_q];
  assign x_ext = {{COEFF_WIDTH{x_sel[DATA_WIDTH-1]}}, x_sel};
  assign c_ext = {{DATA_WIDTH{c_sel[COEFF_WIDTH-1]}}, c_sel};
  assign prod  = x_ext * c_ext;
  assign dq    = prod[PW-1] ? ((prod + DQ_BIAS) >>> FRAC_BITS)
                            : (prod >>> FRAC_BITS);

`ifdef FIR_DECIM_SAT_EN
  localparam logic signed [PW-1:0] SAT_MAX =
    {{(PW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN =
    {{(PW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  always_comb begin
    y = acc_q[DATA_WIDTH-1:0];
    if (acc_q > SAT_MAX) begin
      y = SAT_MAX[DATA_WIDTH-1:0];
    end else if (acc_q < SAT_MIN) begin
      y = SAT_MIN[DATA_WIDTH-1:0];
    end
  end
`else
  assign y = acc_q[DATA_WIDTH-1:0];
`endif

  // ---------------------------------------------------------------------------
  // Control FSM, delay line, coefficient bank and accumulator
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      dcnt_q        <= '0;
      tap_q         <= '0;
      acc_q         <= '0;
      in_full_q     <= 1'b0;
      coeff_ready_q <= 1'b1;
      for (int i = 0; i < NUM_TAPS; i++) begin
        x_q[i] <= '0;
        c_q[i] <= '0;
      end
    end else begin
      // coeff_ready_q is only high in IDLE, so a write never disturbs a MAC.
      if (coeff_we && (int'(coeff_addr) < NUM_TAPS)) begin
        c_q[coeff_addr] <= coeff_din;
      end

      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            x_q[0] <= din;
            for (int i = 1; i < NUM_TAPS; i++) begin
              x_q[i] <= x_q[i-1];
            end
            if (dcnt_q == DCNT_LAST) begin
              dcnt_q        <= '0;
              tap_q         <= '0;
              acc_q         <= '0;
              state_q       <= ST_MAC;
              in_full_q     <= 1'b1;
              coeff_ready_q <= 1'b0;
            end else begin
              dcnt_q <= dcnt_q + 1'b1;
            end
          end
        end

        ST_MAC: begin
          acc_q <= acc_q + dq;
          if (tap_q == TAP_LAST) begin
            state_q <= ST_WRITE;
          end else begin
            tap_q <= tap_q + 1'b1;
          end
        end

        ST_WRITE: begin
          if (!fifo_full) begin
            state_q       <= ST_IDLE;
            in_full_q     <= 1'b0;
            coeff_ready_q <= 1'b1;
          end
        end

        default: begin
          state_q       <= ST_IDLE;
          in_full_q     <= 1'b0;
          coeff_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_full     = in_full_q;
  assign coeff_ready = coeff_ready_q;

  // ---------------------------------------------------------------------------
  // Output FIFO: storage array plus a registered head word. The head register
  // refills from the array whenever it is empty or being popped, so dout and
  // out_empty come straight from flops. Occupancy counts both the array and
  // the head, giving OUT_DEPTH results in total.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [OUT_DEPTH];
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [OCW-1:0]        mem_cnt_q;
  logic [OCW-1:0]        occ;
  logic                  head_vld_q;
  logic [DATA_WIDTH-1:0] head_q;

  assign occ       = mem_cnt_q + OCW'(head_vld_q);
  assign fifo_full = (occ == FIFO_CAP);
  assign push      = (state_q == ST_WRITE) && !fifo_full;
  assign pop       = out_rd_en && head_vld_q;
  assign load_head = (!head_vld_q || pop) && (mem_cnt_q != '0);

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_q] <= y;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      head_vld_q <= 1'b0;
      head_q     <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end

      if (load_head) begin
        head_q     <= mem[rd_ptr_q];
        rd_ptr_q   <= rd_ptr_q + 1'b1;
        head_vld_q <= 1'b1;
      end else if (pop) begin
        head_vld_q <= 1'b0;
      end

      case ({push, load_head})
        2'b10:   mem_cnt_q <= mem_cnt_q + 1'b1;
        2'b01:   mem_cnt_q <= mem_cnt_q - 1'b1;
        default: mem_cnt_q <= mem_cnt_q;
      endcase
    end
  end

  assign dout      = head_q;
  assign out_empty = !head_vld_q;

endmodule

// File: tb/tb_fir_decim_stream.sv
// -----------------------------------------------------------------------------
// tb_fir_decim_stream
//   Scoreboard bench for fir_decim_stream (32 taps, decimate by 8, 10 fraction
//   bits, 16-deep output FIFO). A behavioural model computes each expected
//   result when the DECIM-th sample is driven; a pop process compares the
//   FIFO head against the queue front.
// -----------------------------------------------------------------------------
module tb_fir_decim_stream;

  localparam int DW  = 32;
  localparam int CW  = 32;
  localparam int NT  = 32;
  localparam int DEC = 8;
  localparam int FB  = 10;
  localparam int OD  = 16;

  logic          clock;
  logic          reset;
  logic [DW-1:0] din;
  logic          in_wr_en;
  logic          in_full;
  logic          coeff_wr_en;
  logic [4:0]    coeff_addr;
  logic [CW-1:0] coeff_din;
  logic          coeff_ready;
  logic [DW-1:0] dout;
  logic          out_rd_en;
  logic          out_empty;

  fir_decim_stream #(
    .DATA_WIDTH (DW),
    .COEFF_WIDTH(CW),
    .NUM_TAPS   (NT),
    .DECIM      (DEC),
    .FRAC_BITS  (FB),
    .OUT_DEPTH  (OD)
  ) u_dut (
    .clock      (clock),
    .reset      (reset),
    .din        (din),
    .in_wr_en   (in_wr_en),
    .in_full    (in_full),
    .coeff_wr_en(coeff_wr_en),
    .coeff_addr (coeff_addr),
    .coeff_din  (coeff_din),
    .coeff_ready(coeff_ready),
    .dout       (dout),
    .out_rd_en  (out_rd_en),
    .out_empty  (out_empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  int n_out = 0;
  int n_acc = 0;
  bit pop_en = 1'b0;

  logic signed [DW-1:0] mx [NT];
  logic signed [CW-1:0] mc [NT];
  int                   mcnt;
  logic [DW-1:0]        sb [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: exact 64-bit products, C-style division (toward zero).
  // ---------------------------------------------------------------------------
  function automatic logic [DW-1:0] model_y();
    longint acc;
    longint p;
    logic [DW-1:0] r;
    acc = 0;
    for (int k = 0; k < NT; k++) begin
      p   = longint'(mc[k]) * longint'(mx[k]);
      acc = acc + p / (longint'(1) << FB);
    end
    r = DW'(acc);
`ifdef FIR_DECIM_SAT_EN
    if (acc > 64'sd2147483647) r = 32'h7FFF_FFFF;
    else if (acc < -64'sd2147483648) r = 32'h8000_0000;
`endif
    return r;
  endfunction

  function automatic void model_sample(input logic signed [DW-1:0] v);
    for (int i = NT - 1; i > 0; i--) mx[i] = mx[i-1];
    mx[0] = v;
    n_acc++;
    mcnt++;
    if (mcnt == DEC) begin
      mcnt = 0;
      sb.push_back(model_y());
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NT; i++) begin
      mx[i] = '0;
      mc[i] = '0;
    end
    mcnt = 0;
    sb.delete();
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers: all called and returning on a falling edge.
  // ---------------------------------------------------------------------------
  task automatic send(input logic signed [DW-1:0] v, input bit cw = 1'b0,
                      input int ca = 0, input logic signed [CW-1:0] cv = '0);
    int guard = 0;
    while (in_full && guard < 4000) begin
      @(negedge clock);
      guard++;
    end
    if (in_full) begin
      chk("in_full_timeout", {63'd0, in_full}, 64'd0);
    end else begin
      din      = v;
      in_wr_en = 1'b1;
      if (cw) begin
        coeff_wr_en = 1'b1;
        coeff_addr  = 5'(ca);
        coeff_din   = cv;
        mc[ca]      = cv;
      end
      model_sample(v);
      @(negedge clock);
      in_wr_en    = 1'b0;
      coeff_wr_en = 1'b0;
    end
  endtask

  task automatic load_coeff(input int k, input logic signed [CW-1:0] v);
    int guard = 0;
    while (!coeff_ready && guard < 4000) begin
      @(negedge clock);
      guard++;
    end
    if (!coeff_ready) begin
      chk("coeff_ready_timeout", {63'd0, coeff_ready}, 64'd1);
    end else begin
      coeff_wr_en = 1'b1;
      coeff_addr  = 5'(k);
      coeff_din   = v;
      mc[k]       = v;
      @(negedge clock);
      coeff_wr_en = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while (sb.size() != 0 && guard < 3000) begin
      @(negedge clock);
      guard++;
    end
    chk({tag, "_drain"}, 64'(sb.size()), 64'd0);
    repeat (2) @(negedge clock);
  endtask

  // ---------------------------------------------------------------------------
  // Pop process: compare FIFO head against the scoreboard, then pop it.
  // ---------------------------------------------------------------------------
  initial begin
    logic [DW-1:0] exp_v;
    out_rd_en = 1'b0;
    forever begin
      @(negedge clock);
      if (reset && pop_en && !out_empty) begin
        if (sb.size() == 0) begin
          chk("sb_level", 64'(sb.size()), 64'd1);
        end else begin
          exp_v = sb.pop_front();
          chk("dout", {32'd0, dout}, {32'd0, exp_v});
          n_out++;
        end
        out_rd_en = 1'b1;
      end else begin
        out_rd_en = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int base_out;
    int base_acc;
    int lat;

    din         = '0;
    in_wr_en    = 1'b0;
    coeff_wr_en = 1'b0;
    coeff_addr  = '0;
    coeff_din   = '0;
    reset       = 1'b1;
    model_reset();
    #2 reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_out_empty", {63'd0, out_empty},   64'd1);
    chk("rst_in_full",   {63'd0, in_full},     64'd0);
    chk("rst_coeff_rdy", {63'd0, coeff_ready}, 64'd1);
    chk("rst_dout",      {32'd0, dout},        64'd0);
    reset = 1'b1;
    @(negedge clock);
    pop_en = 1'b1;

    // impulse: c[k]=(k+1)<<10, 1 then 31 zeros -> 8,16,24,32
    for (int k = 0; k < NT; k++) load_coeff(k, (k + 1) << 10);
    base_out = n_out;
    send(1);
    repeat (31) send(0);
    drain("impulse");
    chk("impulse_count", 64'(n_out - base_out), 64'd4);

    // decimation: c[0]=1<<10, feed 0..799 -> 7,15,...,799
    for (int k = 0; k < NT; k++) load_coeff(k, (k == 0) ? (1 << 10) : 0);
    base_out = n_out;
    for (int i = 0; i < 800; i++) send(i);
    drain("decim");
    chk("decim_count", 64'(n_out - base_out), 64'd100);

    // truncation toward zero with c[0]=1, plus accept-to-out_empty latency
    load_coeff(0, 1);
    repeat (7) send(0);
    send(-1023);
    lat = 0;
    while (out_empty && lat < 200) begin
      @(negedge clock);
      lat++;
    end
    chk("latency", 64'(lat), 64'(NT + 2));
    drain("trunc_neg");
    repeat (7) send(0);
    send(1023);
    drain("trunc_pos");

    // coefficient gating: write during MAC dropped, write in IDLE applies next
    load_coeff(0, 1 << 10);
    repeat (8) send(5);
    coeff_wr_en = 1'b1;
    coeff_addr  = 5'd0;
    coeff_din   = 3 << 10;
    chk("gate_ready", {63'd0, coeff_ready}, 64'd0);
    @(negedge clock);
    coeff_wr_en = 1'b0;
    drain("gate_mac");
    repeat (8) send(7);
    drain("gate_dropped");
    repeat (7) send(7);
    send(7, 1'b1, 0, 3 << 10);
    drain("gate_idle");

    // backpressure: never pop until 16 stored and the 17th stalls in WRITE
    for (int k = 0; k < NT; k++) load_coeff(k, (((k * 37) % 23) - 11) * 64);
    pop_en   = 1'b0;
    base_acc = n_acc;
    base_out = n_out;
    fork
      begin
        for (int i = 0; i < 160; i++) send(int'($urandom_range(0, 4000)) - 2000);
      end
      begin
        repeat (1200) @(negedge clock);
        chk("bp_accepted", 64'(n_acc - base_acc), 64'd136);
        chk("bp_in_full",  {63'd0, in_full},      64'd1);
        chk("bp_pending",  64'(sb.size()),        64'd17);
        pop_en = 1'b1;
      end
    join
    drain("bp");
    chk("bp_count", 64'(n_out - base_out), 64'd20);

    // full-scale products: wrap by default, clamp when saturation is built in
    for (int k = 0; k < NT; k++) load_coeff(k, (k == 0) ? 32'sh7FFF_FFFF : 0);
    repeat (7) send(0);
    send(32'sh7FFF_FFFF);
    drain("big_pos");
    repeat (7) send(0);
    send(32'sh8000_0000);
    drain("big_neg");

    // async reset five cycles into a MAC
    for (int k = 0; k < NT; k++) load_coeff(k, (k + 1) << 10);
    repeat (8) send(100);
    repeat (5) @(negedge clock);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_out_empty", {63'd0, out_empty},   64'd1);
    chk("mid_rst_in_full",   {63'd0, in_full},     64'd0);
    chk("mid_rst_coeff_rdy", {63'd0, coeff_ready}, 64'd1);
    chk("mid_rst_dout",      {32'd0, dout},        64'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    base_out = n_out;
    repeat (8) send(50);
    drain("post_rst");
    chk("post_rst_count", 64'(n_out - base_out), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
